// File: rtl/ppu_write_queue.sv
// ppu_write_queue
//   Buffers CPU writes to the PPU tables (attribute, sprite, color) and
//   replays them into the tables only while the display is blanked, so the
//   renderer never sees a table change in the middle of a visible line.
//
//   Avalon side: a write with address[11:10] in 0..2 is queued as
//   {address, writedata}. Region 3 is a control register that is never
//   queued: bit 0 clears the sticky overflow flag, bit 1 flushes the queue.
//   waitrequest is raised while the queue is full (never for region 3).
//
//   Table side: in the DRAIN state one entry is popped per clock, oldest
//   first. It appears registered on w_address/w_data one cycle later with a
//   one-hot mem_write strobe selected by the entry's region.
//
//   Optional build macro PPU_WQ_HBLANK_DRAIN_EN: also drains during the
//   horizontal blank of visible lines (hcount 1280..1535, vcount < 480).
//   Without it, draining happens only in vertical blank (vcount >= 480).
//
// Ports
//   clk          system clock
//   reset_n      synchronous active-low reset
//   chipselect   Avalon slave select
//   write        Avalon write strobe
//   address      Avalon address, [11:10] selects region
//   writedata    Avalon write data
//   waitrequest  high while queue full
//   hcount       horizontal counter from vga_counters
//   vcount       vertical counter from vga_counters
//   mem_write    one-hot table write strobe (bit = region)
//   w_address    table write address
//   w_data       table write data
//   level        number of queued entries, 0..DEPTH
//   overflow     sticky: a write was dropped while full
module ppu_write_queue #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic        write,
    input  logic [11:0] address,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic [2:0]  mem_write,
    output logic [11:0] w_address,
    output logic [31:0] w_data,
    output logic [6:0]  level,
    output logic        overflow
);
    localparam int         PTR_W      = $clog2(DEPTH);
    localparam logic [6:0] LEVEL_FULL = 7'(DEPTH);
    localparam logic [0:0] FILL       = 1'b0;
    localparam logic [0:0] DRAIN      = 1'b1;

`ifdef PPU_WQ_HBLANK_DRAIN_EN
    localparam logic HBLANK_EN = 1'b1;
`else
    localparam logic HBLANK_EN = 1'b0;
`endif

    function automatic logic [2:0] region_strobe(input logic [1:0] region);
        case (region)
            2'd0:    region_strobe = 3'b001;
            2'd1:    region_strobe = 3'b010;
            2'd2:    region_strobe = 3'b100;
            default: region_strobe = 3'b000;
        endcase
    endfunction

    logic [0:0]       state;
    logic [0:0]       state_next;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [6:0]       level_q;
    logic [6:0]       level_next;
    logic             overflow_q;
    logic [43:0]      mem [DEPTH];
    logic [43:0]      rd_entry;

    logic             bus_wr;
    logic             ctrl_wr;
    logic             push_req;
    logic             push_ok;
    logic             flush;
    logic             full;
    logic             vblank;
    logic             hblank;
    logic             window;
    logic             pop_p0;

    logic [2:0]       mem_write_p1;
    logic [11:0]      w_address_p1;
    logic [31:0]      w_data_p1;

    assign bus_wr   = chipselect & write;
    assign ctrl_wr  = bus_wr & (address[11:10] == 2'd3);
    assign push_req = bus_wr & (address[11:10] != 2'd3);
    assign full     = (level_q == LEVEL_FULL);
    assign push_ok  = push_req & ~full;
    assign flush    = ctrl_wr & writedata[1];

    // Control-region writes are registers, so they never stall the bus.
    assign waitrequest = full & ~(chipselect & (address[11:10] == 2'd3));

    assign vblank = (vcount >= 10'd480);
    assign hblank = (vcount < 10'd480) & (hcount >= 11'd1280) & (hcount <= 11'd1535);
    assign window = vblank | (hblank & HBLANK_EN);

    // Stage p0: pop decision and queue head; the pop only happens while the
    // window is open right now, so draining stops in the first closed cycle.
    assign pop_p0   = (state == DRAIN) & window & (level_q != 7'd0);
    assign rd_entry = mem[rd_ptr];

    always_comb begin
        level_next = level_q;
        case ({push_ok, pop_p0})
            2'b10:   level_next = level_q + 7'd1;
            2'b01:   level_next = level_q - 7'd1;
            default: level_next = level_q;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (window && level_q != 7'd0) state_next = DRAIN;
            default: if (!window || level_next == 7'd0) state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n && push_ok && !flush) begin
            mem[wr_ptr] <= {address, writedata};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= FILL;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level_q      <= 7'd0;
            overflow_q   <= 1'b0;
            mem_write_p1 <= 3'b000;
            w_address_p1 <= 12'd0;
            w_data_p1    <= 32'd0;
        end else begin
            if (ctrl_wr && writedata[0]) begin
                overflow_q <= 1'b0;
            end else if (push_req && full) begin
                overflow_q <= 1'b1;
            end

            if (flush) begin
                // Flush wins over any pop in the same cycle: nothing is written out.
                state        <= FILL;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                level_q      <= 7'd0;
                mem_write_p1 <= 3'b000;
            end else begin
                state   <= state_next;
                level_q <= level_next;
                if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_p0)  rd_ptr <= rd_ptr + PTR_W'(1);

                // Stage p1: registered table write; address/data hold when idle.
                mem_write_p1 <= pop_p0 ? region_strobe(rd_entry[43:42]) : 3'b000;
                if (pop_p0) begin
                    w_address_p1 <= rd_entry[43:32];
                    w_data_p1    <= rd_entry[31:0];
                end
            end
        end
    end

    assign mem_write = mem_write_p1;
    assign w_address = w_address_p1;
    assign w_data    = w_data_p1;
    assign level     = level_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/ppu_write_queue.md
PPU_WRITE_QUEUE -- requirements
Module: ppu_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, queue entries (power of 2, 4..64).
REQ-002 SHALL have port clk  input  1  system clock (50 MHz), sole clock.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port chipselect  input  1  Avalon slave select.
REQ-005 SHALL have port write  input  1  Avalon write strobe.
REQ-006 SHALL have port address  input  12  Avalon address; [11:10] region (0 attr, 1 sprite, 2 color, 3 control).
REQ-007 SHALL have port writedata  input  32  Avalon write data.
REQ-008 SHALL have port waitrequest  output  1  high while queue full.
REQ-009 SHALL have port hcount  input  11  from vga_counters.
REQ-010 SHALL have port vcount  input  10  from vga_counters.
REQ-011 SHALL have port mem_write  output  3  one-hot table write strobe to PPU tables.
REQ-012 SHALL have port w_address  output  12  table write address.
REQ-013 SHALL have port w_data  output  32  table write data.
REQ-014 SHALL have port level  output  7  current entry count, 0..DEPTH.
REQ-015 SHALL have port overflow  output  1  sticky: write dropped while full.

Function
REQ-016 SHALL treat chipselect&write with address[11:10] in 0..2 as a push of {address, writedata}.
REQ-017 SHALL drive waitrequest combinationally = (level == DEPTH); never for region-3 writes.
REQ-018 SHALL drop a push arriving while full, leave contents unchanged, set overflow next cycle.
REQ-019 SHALL treat region-3 write as control, never queued: writedata[0]=1 clears overflow; writedata[1]=1 flushes (level->0, pointers equal) next cycle.
REQ-020 SHALL open the drain window when vcount >= 480 (vertical blank, 480..524).
REQ-021 SHALL implement FSM states FILL and DRAIN; FILL->DRAIN when window open and level>0; DRAIN->FILL when window closes or level reaches 0 after pop.
REQ-022 SHALL pop exactly one entry per clock in DRAIN, oldest first.
REQ-023 SHALL register outputs: entry popped in cycle N appears on w_address/w_data with mem_write[address[11:10]]=1 in cycle N+1, all mem_write bits 0 otherwise.
REQ-024 SHALL keep w_address/w_data holding last popped values when mem_write is 0.
REQ-025 SHALL allow simultaneous push and pop; level unchanged, pushed entry retained behind others.
REQ-026 SHALL accept a push into an empty queue during an open window and pop it no earlier than the following cycle.
REQ-027 SHALL give flush priority over simultaneous push and pop in the same cycle; pushed entry discarded, no mem_write issued next cycle.
REQ-028 SHALL stop popping in the first cycle the window is closed; unpopped entries remain for next window.
REQ-029 SHALL wrap read/write pointers modulo DEPTH with level as separate counter.

Reset
REQ-030 SHALL, when reset_n=0 at a clk edge, set state FILL, level 0, pointers 0, mem_write 0, w_address 0, w_data 0, overflow 0.
REQ-031 SHALL discard all queued entries on reset mid-drain; no mem_write pulse in the cycle after reset.
REQ-032 SHALL ignore pushes and control writes in cycles where reset_n=0.

Configuration
REQ-033 SHALL, with macro PPU_WQ_HBLANK_DRAIN_EN defined, also open the window when vcount < 480 and 1280 <= hcount <= 1535.
REQ-034 SHALL, without PPU_WQ_HBLANK_DRAIN_EN, open the window only during vertical blank per REQ-020.

Verification
REQ-035 SHALL test: 3 pushes (0x005/0x11, 0x410/0x22, 0x803/0x33) at vcount 100, then vcount=480 -> three consecutive mem_write pulses 001,010,100 with matching address/data in order.
REQ-036 SHALL test: DEPTH=16 pushes at vcount 100 -> level 16, waitrequest 1; 17th write ignoring waitrequest -> overflow 1, level 16; control write 0x1 -> overflow 0.
REQ-037 SHALL test: 10 entries, window opens at vcount=524 hcount=1594 -> exactly 5 pops before vcount wraps to 0, level 5 remains.
REQ-038 SHALL test: push during DRAIN with level 4 -> level stays 4 that cycle, pushed entry emerges last.
REQ-039 SHALL test: 8 entries, reset_n low one cycle mid-drain -> level 0, mem_write 0, overflow 0; no further pulses.
REQ-040 SHALL test: with PPU_WQ_HBLANK_DRAIN_EN, entries at vcount 200 drain from hcount 1280; without it, none drain until vcount 480.
